// File: rtl/anim_race_sched_if.sv
// Signal bundle between the race scheduler and the game controller / display side.
// The scheduler takes the slave view; whoever produces steps and restarts takes the master view.
interface anim_race_sched_if;
    logic [2:0] req;
    logic       restart;
    logic [3:0] mode;
    logic       busy;
    logic       win_valid;
    logic [1:0] winner;
    logic       off;

    modport master (
        output req,
        output restart,
        input  mode,
        input  busy,
        input  win_valid,
        input  winner,
        input  off
    );

    modport slave (
        input  req,
        input  restart,
        output mode,
        output busy,
        output win_valid,
        output winner,
        output off
    );
endinterface

// File: rtl/anim_race_sched.sv
// Three-player race scheduler: round-robin step arbitration, per-animal frame tracking,
// held mode codes for a slow display, winner detection with blink, and restore on restart.
module anim_race_sched #(
    parameter int unsigned HOLD_CYCLES  = 600,
    parameter int unsigned HOLD_W       = 10,
    parameter int unsigned BLINK_CYCLES = 250,
    parameter int unsigned BLINK_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    anim_race_sched_if.slave  bus_if
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_DONE    = 2'd2,
        ST_RESTORE = 2'd3
    } state_t;

    localparam logic [3:0]         MODE_IDLE  = 4'b1111;
    localparam logic [1:0]         LAST_FRAME = 2'd3;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    state_t              state_q, state_d;
    logic [2:0]          pending_q, pending_d;
    logic [2:0][1:0]     frame_q, frame_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          phase_q, phase_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [BLINK_W-1:0]  blink_q, blink_d;
    logic [3:0]          mode_q, mode_d;
    logic                busy_q, busy_d;
    logic                win_valid_q, win_valid_d;
    logic [1:0]          winner_q, winner_d;
    logic                off_q, off_d;

    // Requests only count while a race is actually running.
    logic [2:0] req_acc;
    assign req_acc = (state_q == ST_IDLE || state_q == ST_GRANT) ? bus_if.req : 3'b000;

    // Candidate gi is the animal gi places after rr_ptr, wrapping modulo 3.
    logic [1:0] cand [3];
    logic [2:0] cand_hit;

    for (genvar gi = 0; gi < 3; gi++) begin : g_cand
        logic [2:0] sum;
        assign sum          = {1'b0, rr_ptr_q} + 3'(gi);
        assign cand[gi]     = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        assign cand_hit[gi] = pending_q[cand[gi]];
    end

    logic       pick_valid;
    logic [1:0] pick;
    logic [1:0] pick_frame;

    always_comb begin
        pick_valid = |cand_hit;
        pick       = 2'd0;
        if (cand_hit[0]) begin
            pick = cand[0];
        end else if (cand_hit[1]) begin
            pick = cand[1];
        end else if (cand_hit[2]) begin
            pick = cand[2];
        end
    end

    assign pick_frame = frame_q[pick] + 2'd1;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | req_acc;
        frame_d     = frame_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        phase_d     = phase_q;
        hold_d      = hold_q;
        blink_d     = blink_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        win_valid_d = win_valid_q;
        winner_d    = winner_q;
        off_d       = off_q;

        case (state_q)
            ST_IDLE: begin
                mode_d = MODE_IDLE;
                busy_d = 1'b0;
                if (pick_valid) begin
                    frame_d[pick]   = pick_frame;
                    // A fresh pulse on the same edge as the clear keeps the request alive.
                    pending_d[pick] = req_acc[pick];
                    mode_d          = {pick, pick_frame};
                    hold_d          = HOLD_LOAD;
                    rr_ptr_d        = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
                    gnt_d           = pick;
                    busy_d          = 1'b1;
                    state_d         = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (hold_q == '0) begin
                    mode_d = MODE_IDLE;
                    busy_d = 1'b0;
                    if (frame_q[gnt_q] == LAST_FRAME) begin
                        state_d     = ST_DONE;
                        winner_d    = gnt_q;
                        win_valid_d = 1'b1;
                        pending_d   = 3'b000;
                        blink_d     = '0;
                        off_d       = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end

            ST_DONE: begin
                mode_d = MODE_IDLE;
                if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    off_d   = ~off_q;
                end else begin
                    blink_d = blink_q + BLINK_ONE;
                end
            end

            ST_RESTORE: begin
                if (hold_q == '0) begin
                    if (phase_q == 2'd2) begin
                        state_d = ST_IDLE;
                        mode_d  = MODE_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        mode_d  = {phase_q + 2'd1, 2'b00};
                        hold_d  = HOLD_LOAD;
                    end
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                mode_d  = MODE_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Restart overrides everything, including a step request on the same edge.
        if (bus_if.restart) begin
            pending_d   = 3'b000;
            frame_d     = '0;
            rr_ptr_d    = 2'd0;
            win_valid_d = 1'b0;
            winner_d    = 2'd0;
            off_d       = 1'b0;
            blink_d     = '0;
            phase_d     = 2'd0;
            hold_d      = HOLD_LOAD;
            mode_d      = 4'b0000;
            busy_d      = 1'b1;
            state_d     = ST_RESTORE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= 3'b000;
            frame_q     <= '0;
            rr_ptr_q    <= 2'd0;
            gnt_q       <= 2'd0;
            phase_q     <= 2'd0;
            hold_q      <= '0;
            blink_q     <= '0;
            mode_q      <= MODE_IDLE;
            busy_q      <= 1'b0;
            win_valid_q <= 1'b0;
            winner_q    <= 2'd0;
            off_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            frame_q     <= frame_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            phase_q     <= phase_d;
            hold_q      <= hold_d;
            blink_q     <= blink_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            win_valid_q <= win_valid_d;
            winner_q    <= winner_d;
            off_q       <= off_d;
        end
    end

    assign bus_if.mode      = mode_q;
    assign bus_if.busy      = busy_q;
    assign bus_if.win_valid = win_valid_q;
    assign bus_if.winner    = winner_q;
    assign bus_if.off       = off_q;

endmodule
